// File: rtl/mailbox_pkg.sv
// Shared constants for the CPU mailbox: register offsets, STATUS bit
// positions, control bit positions and a STATUS byte builder.
package mailbox_pkg;

  // Register offsets within the 4-byte window (address[1:0])
  localparam logic [1:0] MB_DATA   = 2'd0;
  localparam logic [1:0] MB_STATUS = 2'd1;
  localparam logic [1:0] MB_RXCNT  = 2'd2;
  localparam logic [1:0] MB_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;

  // Control register bit positions (write to offset MB_CTRL)
  localparam int MB_CTRL_CLR   = 0;
  localparam int MB_CTRL_FLUSH = 1;

  // Pack the individual flags into the STATUS byte; bits 7:6 read zero.
  function automatic logic [7:0] mb_status(
    input logic rx_empty,
    input logic rx_full,
    input logic tx_empty,
    input logic tx_full,
    input logic tx_ovf,
    input logic rx_unf
  );
    logic [7:0] s;
    s              = 8'h00;
    s[ST_RX_EMPTY] = rx_empty;
    s[ST_RX_FULL]  = rx_full;
    s[ST_TX_EMPTY] = tx_empty;
    s[ST_TX_FULL]  = tx_full;
    s[ST_TX_OVF]   = tx_ovf;
    s[ST_RX_UNF]   = rx_unf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush. A push while full is still accepted when
// a pop happens on the same edge (the freed slot is reused). The head is
// forced to zero while empty so the storage never needs a reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and occupancy; flush overrides any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are left unreset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/bus_mailbox.sv
// CPU-bus mailbox: 4-byte register window bridging the CPU to a TX and an
// RX byte stream. Build option MAILBOX_STICKY_EN enables the sticky
// tx_overflow / rx_underflow flags and their clear control bit.
module bus_mailbox
  import mailbox_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] BASE  = 8'h0C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic [7:0] rdata,
  output logic       hit,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          bus_wr;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          ctrl_wr, flush;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_overflow, rx_underflow;

  // Address decode: a bus action needs both the strobe and a window hit
  assign hit     = (address[7:2] == BASE[7:2]);
  assign bus_wr  = write & hit;
  assign tx_push = bus_wr & (address[1:0] == MB_DATA);
  assign rx_pop  = bus_wr & (address[1:0] == MB_RXCNT);
  assign ctrl_wr = bus_wr & (address[1:0] == MB_CTRL);
  assign flush   = ctrl_wr & wdata[MB_CTRL_FLUSH];

  // Stream handshakes; rx_ready is held low during reset
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_head;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = ~rx_full & ~reset;
  assign rx_push  = rx_valid & rx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .din   (wdata),
    .head  (tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (rx_data),
    .head  (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

`ifdef MAILBOX_STICKY_EN
  logic clr;
  logic tx_ovf_q, tx_ovf_d;
  logic rx_unf_q, rx_unf_d;

  assign clr = ctrl_wr & wdata[MB_CTRL_CLR];

  // Sticky flags: set on a dropped store or an empty pop, cleared by control
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (clr) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
      if (rx_pop && rx_empty)            rx_unf_d = 1'b1;
    end
  end

  // Sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  assign tx_overflow  = tx_ovf_q;
  assign rx_underflow = rx_unf_q;
`else
  assign tx_overflow  = 1'b0;
  assign rx_underflow = 1'b0;
`endif

  // Register read mux; zero whenever the address misses the window
  always_comb begin
    rdata = 8'h00;
    if (hit) begin
      case (address[1:0])
        MB_DATA:   rdata = rx_head;
        MB_STATUS: rdata = mb_status(rx_empty, rx_full, tx_empty, tx_full,
                                     tx_overflow, rx_underflow);
        MB_RXCNT:  rdata = 8'(rx_count);
        MB_CTRL:   rdata = 8'(tx_count);
        default:   rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Self-checking bench for bus_mailbox: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_bus_mailbox;

  localparam int         DEPTH = 16;
  localparam logic [7:0] BASE  = 8'h0C;
`ifdef MAILBOX_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, write, tx_ready, rx_valid;
  logic [7:0] address, wdata, rx_data;
  logic [7:0] rdata, tx_data;
  logic       hit, tx_valid, rx_ready;

  always #5 clk = ~clk;

  bus_mailbox #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .wdata    (wdata),
    .write    (write),
    .rdata    (rdata),
    .hit      (hit),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0] rxq[$];     // bytes held in RX, head first
  logic [7:0] exp_tx[$];  // scoreboard: accepted stores not yet seen on the stream
  int         tx_cnt_m = 0;
  bit         ovf_m = 1'b0, unf_m = 1'b0;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] model_status();
    logic [7:0] s;
    s = 8'h00;
    s[0] = (rxq.size() == 0);
    s[1] = (rxq.size() == DEPTH);
    s[2] = (tx_cnt_m == 0);
    s[3] = (tx_cnt_m == DEPTH);
    s[4] = STICKY & ovf_m;
    s[5] = STICKY & unf_m;
    return s;
  endfunction

  function automatic logic [7:0] model_rdata(input logic [7:0] a);
    if (a[7:2] != BASE[7:2]) return 8'h00;
    case (a[1:0])
      2'd0:    return (rxq.size() > 0) ? rxq[0] : 8'h00;
      2'd1:    return model_status();
      2'd2:    return 8'(rxq.size());
      default: return 8'(tx_cnt_m);
    endcase
  endfunction

  // Reference model: applies the block's rules to the pre-edge inputs
  initial begin
    bit         mhit, txpop, rxpush, is_ctrl;
    logic [1:0] off;
    forever begin
      @(posedge clk);
      mhit    = (address[7:2] == BASE[7:2]) && write;
      off     = address[1:0];
      is_ctrl = mhit && (off == 2'd3);
      if (reset) begin
        rxq.delete(); exp_tx.delete();
        tx_cnt_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
      end else begin
        txpop  = (tx_cnt_m > 0) && tx_ready;
        rxpush = rx_valid && (rxq.size() < DEPTH);
        if (is_ctrl && wdata[0]) begin ovf_m = 1'b0; unf_m = 1'b0; end
        if (is_ctrl && wdata[1]) begin
          rxq.delete(); exp_tx.delete(); tx_cnt_m = 0;
        end else begin
          if (txpop) tx_cnt_m--;
          if (mhit && off == 2'd0) begin
            if (tx_cnt_m < DEPTH) begin exp_tx.push_back(wdata); tx_cnt_m++; end
            else ovf_m = 1'b1;
          end
          if (mhit && off == 2'd2) begin
            if (rxq.size() == 0) unf_m = 1'b1;
            else void'(rxq.pop_front());
          end
          if (rxpush) rxq.push_back(rx_data);
        end
      end
    end
  end

  // Per-cycle checker of the bus-visible outputs
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("hit", {7'd0, hit}, {7'd0, address[7:2] == BASE[7:2]});
        check("rdata", rdata, model_rdata(address));
        check("tx_valid", {7'd0, tx_valid}, {7'd0, tx_cnt_m > 0});
        check("rx_ready", {7'd0, rx_ready}, {7'd0, !reset && rxq.size() < DEPTH});
      end
    end
  end

  // Stream monitor: each TX handshake pops the scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (chk_en && !reset && tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_data", tx_data, e);
          $display("tx out %02h (expected %02h)", tx_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    address = a; wdata = d; write = 1'b1;
    tick();
    write = 1'b0;
    $display("store %02h to %02h", d, a);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    address = a; write = 1'b0;
    @(negedge clk);
    check(name, rdata, exp);
    $display("read %02h = %02h", a, rdata);
    tick();
  endtask

  task automatic sig_chk(input string name, input logic act_b, input logic exp_b);
    check(name, {7'd0, act_b}, {7'd0, exp_b});
  endtask

  initial begin
    logic [7:0] seq [3];
    logic [7:0] last;
    int         r;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;

    reset = 1'b1; write = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    address = 8'h00; wdata = 8'h00; rx_data = 8'h00;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    sig_chk("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    sig_chk("rst_rx_ready", rx_ready, 1'b1);
    tick();
    rd_chk("rst_status", 8'h0D, 8'h05);
    rd_chk("rst_rxcnt", 8'h0E, 8'h00);
    rd_chk("rst_txcnt", 8'h0F, 8'h00);

    // Three stores held back, then drained in order
    bus_wr(8'h0C, 8'h11); bus_wr(8'h0C, 8'h22); bus_wr(8'h0C, 8'h33);
    rd_chk("txcnt3", 8'h0F, 8'h03);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_seq", tx_data, seq[i]);
      tick();
    end
    @(negedge clk);
    sig_chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;
    tick();

    // Fill RX to full
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    rd_chk("rx_full_status", 8'h0D, 8'h06);
    @(negedge clk);
    sig_chk("rx_ready_full", rx_ready, 1'b0);
    tick();
    rd_chk("rx_head", 8'h0C, 8'hA0);
    bus_wr(8'h0E, 8'h00);
    rd_chk("rx_head_pop", 8'h0C, 8'hA1);
    rd_chk("rxcnt15", 8'h0E, 8'h0F);
    @(negedge clk);
    sig_chk("rx_ready_after_pop", rx_ready, 1'b1);
    tick();

    // TX overflow and clear
    for (int i = 0; i < DEPTH; i++) bus_wr(8'h0C, 8'h40 + 8'(i));
    bus_wr(8'h0C, 8'h77);
    rd_chk("txcnt_full", 8'h0F, 8'h10);
    rd_chk("status_ovf", 8'h0D, STICKY ? 8'h18 : 8'h08);
    bus_wr(8'h0F, 8'h01);
    rd_chk("status_ovf_clr", 8'h0D, 8'h08);

    // Store into full FIFO while the sink pops in the same cycle
    address = 8'h0C; wdata = 8'h77; write = 1'b1; tx_ready = 1'b1;
    tick();
    write = 1'b0; tx_ready = 1'b0;
    rd_chk("txcnt_push_pop_full", 8'h0F, 8'h10);
    tx_ready = 1'b1;
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      last = tx_data;
      tick();
    end
    tx_ready = 1'b0;
    check("last_tx_byte", last, 8'h77);
    @(negedge clk);
    sig_chk("tx_empty_after_drain", tx_valid, 1'b0);
    tick();

    // Flush coinciding with an RX handshake
    bus_wr(8'h0F, 8'h02);
    rd_chk("rxcnt_flushed", 8'h0E, 8'h00);
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'hB0 + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    bus_wr(8'h0C, 8'h55); bus_wr(8'h0C, 8'h66);
    rd_chk("rxcnt5", 8'h0E, 8'h05);
    rd_chk("txcnt2", 8'h0F, 8'h02);
    address = 8'h0F; wdata = 8'h02; write = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
    tick();
    write = 1'b0; rx_valid = 1'b0;
    rd_chk("flush_rxcnt", 8'h0E, 8'h00);
    rd_chk("flush_txcnt", 8'h0F, 8'h00);
    rd_chk("flush_data", 8'h0C, 8'h00);
    rd_chk("flush_status", 8'h0D, 8'h05);

    // RX underflow, STATUS write ignored, clear
    bus_wr(8'h0E, 8'h00);
    rd_chk("status_unf", 8'h0D, STICKY ? 8'h25 : 8'h05);
    bus_wr(8'h0D, 8'hFF);
    rd_chk("status_wr_ignored", 8'h0D, STICKY ? 8'h25 : 8'h05);
    bus_wr(8'h0F, 8'h03);
    rd_chk("status_unf_clr", 8'h0D, 8'h05);
    bus_wr(8'h1C, 8'h99);
    rd_chk("miss_no_store", 8'h0F, 8'h00);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r        = $urandom_range(0, 99);
      reset    = ($urandom_range(0, 299) == 0);
      rx_valid = 1'(($urandom_range(0, 1)));
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) != 0);
      wdata    = 8'($urandom);
      write    = 1'b0;
      address  = 8'($urandom_range(0, 63));
      if (r < 45) begin
        write = 1'b1;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: address = 8'h0C;
          5, 6, 7:       address = 8'h0E;
          8:             address = 8'h0D;
          default:       address = 8'h0F;
        endcase
        if (address == 8'h0F) wdata[1] = ($urandom_range(0, 4) == 0);
      end else if (r < 55) begin
        write = 1'b1;
        wdata[1] = 1'b0;
      end
      if (reset || (write && address[7:2] == BASE[7:2] && address[1:0] == 2'd3 && wdata[1]))
        tx_ready = 1'b0;
      tick();
    end

    // Drain and confirm every accepted byte came out
    reset = 1'b0; write = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    @(negedge clk);
    sig_chk("final_tx_valid", tx_valid, 1'b0);
    check("final_tx_leftover", 8'(exp_tx.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
